// File: rtl/aes_key_expand.sv
// AES-128 on-the-fly key schedule.
// Emits the 11 round keys (index 0..10) one per rk_valid/rk_ready transfer.
// The next round key is computed combinationally from the key register
// through four S-boxes and the XOR chain, and is registered on the transfer
// edge, so a consumer holding rk_ready high sees one key per cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; busy=0, rk_valid=0
//   EMIT  | presenting round key rk_idx; advance on each transfer

// AES S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
// Written arithmetically rather than as a table so the mapping is
// self-evidently correct; zero maps to zero under x^254, giving sbox(0)=63.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Inverse via x^254 = x^2 * x^4 * ... * x^128, then affine transform.
  always_comb begin
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end

endmodule

module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic         busy,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd10;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  temp;
  logic [31:0]  nw0, nw1, nw2, nw3;

  // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
  assign rot_w3 = {key_q[23:0], key_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot_w3[8*g +: 8]),
      .s (sub_w3[8*g +: 8])
    );
  end

  assign temp = sub_w3 ^ {rcon_q, 24'h000000};
  assign nw0  = key_q[127:96] ^ temp;
  assign nw1  = key_q[95:64]  ^ nw0;
  assign nw2  = key_q[63:32]  ^ nw1;
  assign nw3  = key_q[31:0]   ^ nw2;

  assign rk_out = key_q;
  assign rk_idx = idx_q;
  assign done   = done_q;

  // State and datapath registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  // Next-state, next round key and handshake outputs.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    idx_d    = idx_q;
    rcon_d   = rcon_q;
    done_d   = 1'b0;
    busy     = 1'b0;
    rk_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d  = {nw0, nw1, nw2, nw3};
            idx_d  = idx_q + 4'd1;
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus pushes the expected round
// key sequence, a negedge monitor pops and compares on every transfer.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         start;
  logic         busy;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .start    (start),
    .busy     (busy),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } sb_t;

  sb_t sb_q[$];

  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] zero_rk [0:10];
  bit           zero_chk [0:10];

  bit           prev_stall = 1'b0;
  logic [127:0] prev_out;
  logic [3:0]   prev_idx;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_fips();
    for (int i = 0; i < 11; i++) sb_q.push_back('{idx: 4'(i), key: fips_rk[i], chk: 1'b1});
  endtask

  task automatic push_zero();
    for (int i = 0; i < 11; i++) sb_q.push_back('{idx: 4'(i), key: zero_rk[i], chk: zero_chk[i]});
  endtask

  task automatic do_start(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = ~k;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},     128'(busy),     128'(0));
    check({tag, "_valid"},    128'(rk_valid), 128'(0));
    check({tag, "_done"},     128'(done),     128'(0));
    check({tag, "_idx"},      128'(rk_idx),   128'(0));
    check({tag, "_rk_out"},   rk_out,         128'h0);
  endtask

  // Monitor: compare every transfer against the scoreboard, check stall
  // stability and that done follows exactly 11 transfers.
  always @(negedge clk) begin
    if (rst) begin
      xfer_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && rk_valid) begin
        check("stall_rk_out", rk_out, prev_out);
        check("stall_rk_idx", 128'(rk_idx), 128'(prev_idx));
      end
      if (rk_valid && rk_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: transfer idx %0d with no expected entry", rk_idx);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_idx", 128'(rk_idx), 128'(e.idx));
          if (e.chk) check("sb_key", rk_out, e.key);
        end
        xfer_cnt++;
      end
      if (done) begin
        check("done_after_11", 128'(xfer_cnt), 128'(11));
        xfer_cnt = 0;
        done_cnt++;
      end
      prev_stall = rk_valid && !rk_ready;
      prev_out   = rk_out;
      prev_idx   = rk_idx;
    end
  end

  initial begin
    int n;
    int saved_done;

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) begin
      zero_rk[i]  = 128'h0;
      zero_chk[i] = 1'b0;
    end
    zero_rk[0]   = 128'h0;
    zero_chk[0]  = 1'b1;
    zero_rk[1]   = 128'h62636363626363636263636362636363;
    zero_chk[1]  = 1'b1;
    zero_rk[10]  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    zero_chk[10] = 1'b1;

    rst      = 1'b1;
    start    = 1'b0;
    key_in   = 128'h0;
    rk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 key, rk_ready held high: done in cycle T+12, one cycle wide
    push_fips();
    do_start(fips_rk[0]);
    wait_done(50, n);
    check("fips_done_latency", 128'(n), 128'(11));
    check("fips_done_busy", 128'(busy), 128'(0));
    check("fips_done_valid", 128'(rk_valid), 128'(0));
    @(posedge clk); #1;
    check("fips_done_pulse", 128'(done), 128'(0));

    // Zero key
    push_zero();
    do_start(128'h0);
    wait_done(50, n);
    check("zero_done_latency", 128'(n), 128'(11));
    @(posedge clk); #1;

    // Pseudo-random backpressure
    push_fips();
    do_start(fips_rk[0]);
    n = 0;
    while (!done && n < 400) begin
      rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    rk_ready = 1'b1;
    check("bp_done_seen", 128'(done), 128'(1));
    @(posedge clk); #1;

    // start with a different key during EMIT is ignored
    push_fips();
    do_start(fips_rk[0]);
    repeat (2) @(posedge clk);
    #1;
    key_in = {4{32'hdeadbeef}};
    start  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b0;
    wait_done(50, n);
    check("busy_start_done_latency", 128'(n + 5), 128'(11));
    @(posedge clk); #1;

    // Mid-run reset at idx 5
    push_fips();
    do_start(fips_rk[0]);
    n = 0;
    while (rk_idx != 4'd5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reach_idx5", 128'(rk_idx), 128'(5));
    saved_done = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    sb_q.delete();
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("midrst_no_done", 128'(done_cnt), 128'(saved_done));
    push_fips();
    do_start(fips_rk[0]);
    wait_done(50, n);
    check("midrst_rerun_latency", 128'(n), 128'(11));
    @(posedge clk); #1;

    // Back-to-back: start in the done cycle
    push_zero();
    do_start(128'h0);
    wait_done(50, n);
    check("b2b_first_done", 128'(done), 128'(1));
    push_fips();
    do_start(fips_rk[0]);
    check("b2b_valid", 128'(rk_valid), 128'(1));
    check("b2b_idx0", 128'(rk_idx), 128'(0));
    check("b2b_key0", rk_out, fips_rk[0]);
    wait_done(50, n);
    check("b2b_second_latency", 128'(n), 128'(11));
    repeat (2) @(posedge clk);
    #1;

    check("sb_drained", 128'(sb_q.size()), 128'(0));
    check("runs_completed", 128'(done_cnt), 128'(7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

AES-128 on-the-fly key schedule. Accepts a 128-bit cipher key and emits the 11 round keys (index 0..10) in order, one per accepted handshake. Sits between the key-load interface and the round datapath. Instantiates four `aes_sbox` instances for SubWord and consumes their outputs directly.

## Interface
Parameters: none (AES-128 only, fixed 11 round keys).

Ports:
- `clk`  in  1  system clock, all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high; one clock domain.
- `key_in`  in  128  cipher key. Sampled only in the cycle `start` is accepted. Bits [127:96] = w0, byte order as FIPS-197, MSB byte first.
- `start`  in  1  request expansion. Accepted only when `busy`=0.
- `busy`  out  1  high from the cycle after `start` is accepted until round key 10 is accepted.
- `rk_out`  out  128  current round key, same word and byte layout as `key_in`.
- `rk_idx`  out  4  round index of `rk_out`, 0..10.
- `rk_valid`  out  1  `rk_out` and `rk_idx` are valid.
- `rk_ready`  in  1  consumer accepts the key; a transfer occurs when `rk_valid` && `rk_ready`.
- `done`  out  1  one-cycle pulse after round key 10 transfers.

## Operation
- States: IDLE, EMIT.
- **IDLE**
  - `busy`=0, `rk_valid`=0.
  - `start`=1 → load `key_in` into the key register, `rk_idx`←0, rcon←8'h01, go to EMIT.
- **EMIT**
  - `busy`=1, `rk_valid`=1, `rk_out` = key register.
  - On transfer with `rk_idx`<10:
    - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
    - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}; SubWord applies `aes_sbox` to each byte.
    - w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
    - `rk_idx`++.
    - rcon ← xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00). Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - On transfer with `rk_idx`=10 → go to IDLE, assert `done` for the next cycle.
- Backpressure: while `rk_valid`=1 and `rk_ready`=0, `rk_out`, `rk_idx` and rcon hold stable.
- `start` while `busy`=1 is ignored and does not alter the key register.
- `start` in the cycle `done` is high is accepted, because `busy`=0 then.
- `rk_ready` in IDLE is ignored.
- All arithmetic is GF(2) XOR. `rk_idx` never exceeds 10 and never wraps.
- Reset values: `busy`=0, `rk_valid`=0, `done`=0, `rk_idx`=0, `rk_out`=128'h0, rcon=8'h01, state=IDLE.
- `rst` asserted mid-expansion aborts immediately to reset values. No `done` pulse is emitted for the aborted run.

## Timing
- `start` accepted at edge T → `rk_valid`=1, `rk_idx`=0 visible after T (cycle T+1).
- Next round key is combinational from the register through the S-boxes and XOR chain. It is registered on the transfer edge, so there are no bubbles: with `rk_ready` held high, index k is presented in cycle T+1+k.
- Index 10 transfers in cycle T+11. In cycle T+12: `done`=1, `busy`=0, `rk_valid`=0.
- `done` is high for exactly one cycle.
- Minimum start-to-start spacing is 12 cycles.
- Critical path: 4 parallel S-boxes plus a 4-deep XOR chain, with no pipelining.

## Test plan
- **FIPS-197 key**
  - Stimulus: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1.
  - Required response:
    - idx0 = key_in.
    - idx1 = a0fafe1788542cb123a339392a6c7605.
    - idx2 = f2c295f27a96b9435935807a7359f67f.
    - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
    - `done` in cycle T+12.
- **Zero key**
  - Stimulus: `key_in`=0.
  - Required response: idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- **Backpressure**
  - Stimulus: toggle `rk_ready` pseudo-randomly.
  - Required response: `rk_out` and `rk_idx` stable while stalled; the sequence is identical to the FIPS run; `done` arrives after exactly 11 transfers.
- **Start while busy**
  - Stimulus: assert `start` with a different `key_in` during EMIT.
  - Required response: ignored; FIPS sequence unaffected.
- **Mid-run reset**
  - Stimulus: assert `rst` at idx 5.
  - Required response: next cycle all outputs at reset values with no `done`. A subsequent `start` produces the full sequence from idx 0.
- **Back-to-back**
  - Stimulus: assert `start` in the `done` cycle.
  - Required response: new run accepted; idx0 of the new key appears the following cycle.
